// File: rtl/axil_rd_arbiter.sv
// axil_rd_arbiter
//   Round-robin arbiter that shares one AXI4-lite read master port among
//   S_COUNT AXI4-lite read requester ports. Only one read is in flight at a
//   time: grant, accept AR, forward AR, collect R, return R, rearbitrate.
//
// Ports
//   clk, rst_n       clock, synchronous active-low reset
//   s_axil_ar*       per-port read address channels (port i at slice i)
//   s_axil_r*        per-port read data channels; data/resp replicated,
//                    rvalid one-hot (granted port only) or zero
//   m_axil_ar*       forwarded read address channel
//   m_axil_r*        downstream read data channel
//   grant            index of the current / most recently granted port
//   busy             high whenever the FSM is not in IDLE
//
// state  | meaning
// IDLE   | waiting for any requester; round-robin pick from last+1
// ACCEPT | s_axil_arready[grant] high for this one cycle; capture address
// ADDR   | m_axil_arvalid held with stable address until m_axil_arready
// DATA   | m_axil_rready high, waiting for m_axil_rvalid
// RESP   | s_axil_rvalid[grant] held until s_axil_rready[grant]

module axil_rd_arbiter #(
   parameter int S_COUNT    = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [S_COUNT*ADDR_WIDTH-1:0] s_axil_araddr,
   input  logic [S_COUNT*3-1:0]          s_axil_arprot,
   input  logic [S_COUNT-1:0]            s_axil_arvalid,
   output logic [S_COUNT-1:0]            s_axil_arready,
   output logic [S_COUNT*DATA_WIDTH-1:0] s_axil_rdata,
   output logic [S_COUNT*2-1:0]          s_axil_rresp,
   output logic [S_COUNT-1:0]            s_axil_rvalid,
   input  logic [S_COUNT-1:0]            s_axil_rready,
   output logic [ADDR_WIDTH-1:0]         m_axil_araddr,
   output logic [2:0]                    m_axil_arprot,
   output logic                          m_axil_arvalid,
   input  logic                          m_axil_arready,
   input  logic [DATA_WIDTH-1:0]         m_axil_rdata,
   input  logic [1:0]                    m_axil_rresp,
   input  logic                          m_axil_rvalid,
   output logic                          m_axil_rready,
   output logic [$clog2(S_COUNT)-1:0]    grant,
   output logic                          busy
);

   localparam int GW = $clog2(S_COUNT);
   localparam int IW = GW + 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ACCEPT = 3'd1,
      ADDR   = 3'd2,
      DATA   = 3'd3,
      RESP   = 3'd4
   } state_t;

   state_t                 state_r, state_nx;
   logic [GW-1:0]          grant_r, grant_nx;
   logic [GW-1:0]          last_r, last_nx;
   logic [S_COUNT-1:0]     s_arready_r, s_arready_nx;
   logic [S_COUNT-1:0]     s_rvalid_r, s_rvalid_nx;
   logic                   m_arvalid_r, m_arvalid_nx;
   logic                   m_rready_r, m_rready_nx;
   logic                   busy_r, busy_nx;
   logic                   cap_ar, cap_r;
   logic [ADDR_WIDTH-1:0]  addr_r;
   logic [2:0]             prot_r;
   logic [DATA_WIDTH-1:0]  rdata_r;
   logic [1:0]             rresp_r;
   logic [GW-1:0]          sel;
   logic                   found;
   logic [IW-1:0]          scan;

   // Round-robin pick: first requester scanning last+1, last+2, ... wrapping.
   always_comb begin
      sel   = '0;
      found = 1'b0;
      scan  = '0;
      for (int i = 1; i <= S_COUNT; i++) begin
         scan = {1'b0, last_r} + IW'(i);
         if (scan >= IW'(S_COUNT)) begin
            scan = scan - IW'(S_COUNT);
         end
         if (!found && s_axil_arvalid[scan[GW-1:0]]) begin
            found = 1'b1;
            sel   = scan[GW-1:0];
         end
      end
   end

   always_comb begin
      state_nx     = state_r;
      grant_nx     = grant_r;
      last_nx      = last_r;
      s_arready_nx = s_arready_r;
      s_rvalid_nx  = s_rvalid_r;
      m_arvalid_nx = m_arvalid_r;
      m_rready_nx  = m_rready_r;
      cap_ar       = 1'b0;
      cap_r        = 1'b0;
      case (state_r)
         IDLE: begin
            if (found) begin
               grant_nx          = sel;
               s_arready_nx      = '0;
               s_arready_nx[sel] = 1'b1;
               state_nx          = ACCEPT;
            end
         end
         ACCEPT: begin
            // Requester must still hold arvalid, so the handshake lands here.
            cap_ar       = 1'b1;
            s_arready_nx = '0;
            m_arvalid_nx = 1'b1;
            state_nx     = ADDR;
         end
         ADDR: begin
            if (m_axil_arready) begin
               m_arvalid_nx = 1'b0;
               m_rready_nx  = 1'b1;
               state_nx     = DATA;
            end
         end
         DATA: begin
            if (m_axil_rvalid && m_rready_r) begin
               cap_r                 = 1'b1;
               m_rready_nx           = 1'b0;
               s_rvalid_nx           = '0;
               s_rvalid_nx[grant_r]  = 1'b1;
               state_nx              = RESP;
            end
         end
         RESP: begin
            if (s_axil_rready[grant_r]) begin
               s_rvalid_nx = '0;
               last_nx     = grant_r;
               state_nx    = IDLE;
            end
         end
         default: begin
            s_arready_nx = '0;
            s_rvalid_nx  = '0;
            m_arvalid_nx = 1'b0;
            m_rready_nx  = 1'b0;
            state_nx     = IDLE;
         end
      endcase
      busy_nx = (state_nx != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         grant_r     <= '0;
         last_r      <= GW'(S_COUNT - 1);
         s_arready_r <= '0;
         s_rvalid_r  <= '0;
         m_arvalid_r <= 1'b0;
         m_rready_r  <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_nx;
         grant_r     <= grant_nx;
         last_r      <= last_nx;
         s_arready_r <= s_arready_nx;
         s_rvalid_r  <= s_rvalid_nx;
         m_arvalid_r <= m_arvalid_nx;
         m_rready_r  <= m_rready_nx;
         busy_r      <= busy_nx;
      end
   end

   // Payload registers carry no reset; they are only meaningful with a valid.
   always_ff @(posedge clk) begin
      if (cap_ar) begin
         addr_r <= s_axil_araddr[grant_r*ADDR_WIDTH +: ADDR_WIDTH];
         prot_r <= s_axil_arprot[grant_r*3 +: 3];
      end
      if (cap_r) begin
         rdata_r <= m_axil_rdata;
         rresp_r <= m_axil_rresp;
      end
   end

   assign s_axil_arready = s_arready_r;
   assign s_axil_rvalid  = s_rvalid_r;
   assign s_axil_rdata   = {S_COUNT{rdata_r}};
   assign s_axil_rresp   = {S_COUNT{rresp_r}};
   assign m_axil_araddr  = addr_r;
   assign m_axil_arprot  = prot_r;
   assign m_axil_arvalid = m_arvalid_r;
   assign m_axil_rready  = m_rready_r;
   assign grant          = grant_r;
   assign busy           = busy_r;

endmodule

// File: tb/tb_axil_rd_arbiter.sv
module tb_axil_rd_arbiter;
   localparam int S  = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [S*AW-1:0] s_araddr;
   logic [S*3-1:0]  s_arprot;
   logic [S-1:0]    s_arvalid;
   logic [S-1:0]    s_arready;
   logic [S*DW-1:0] s_rdata;
   logic [S*2-1:0]  s_rresp;
   logic [S-1:0]    s_rvalid;
   logic [S-1:0]    s_rready;
   logic [AW-1:0]   m_araddr;
   logic [2:0]      m_arprot;
   logic            m_arvalid;
   logic            m_arready;
   logic [DW-1:0]   m_rdata;
   logic [1:0]      m_rresp;
   logic            m_rvalid;
   logic            m_rready;
   logic [1:0]      grant;
   logic            busy;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   axil_rd_arbiter #(.S_COUNT(S), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axil_araddr(s_araddr), .s_axil_arprot(s_arprot),
      .s_axil_arvalid(s_arvalid), .s_axil_arready(s_arready),
      .s_axil_rdata(s_rdata), .s_axil_rresp(s_rresp),
      .s_axil_rvalid(s_rvalid), .s_axil_rready(s_rready),
      .m_axil_araddr(m_araddr), .m_axil_arprot(m_arprot),
      .m_axil_arvalid(m_arvalid), .m_axil_arready(m_arready),
      .m_axil_rdata(m_rdata), .m_axil_rresp(m_rresp),
      .m_axil_rvalid(m_rvalid), .m_axil_rready(m_rready),
      .grant(grant), .busy(busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int p, input logic [31:0] a, input logic [2:0] pr, input logic v);
      s_araddr[p*AW +: AW] = a;
      s_arprot[p*3 +: 3]   = pr;
      s_arvalid[p]         = v;
   endtask

   // Downstream responder plus observation of the returned beat; no checking.
   task automatic serve(input logic [31:0] data, input logic [1:0] resp, input bit keep,
                        output int g, output logic [31:0] a, output logic [3:0] rv,
                        output logic [31:0] rd, output logic [1:0] rr, output bit to);
      int n;
      to = 1'b0; g = 0; a = '0; rv = '0; rd = '0; rr = '0;
      n = 0;
      while (m_arvalid !== 1'b1 && n < 40) begin tick(); n++; end
      if (m_arvalid !== 1'b1) begin to = 1'b1; return; end
      g = int'(grant);
      a = m_araddr;
      if (!keep) s_arvalid[g] = 1'b0;
      m_arready = 1'b1;
      tick();
      m_arready = 1'b0;
      m_rvalid = 1'b1; m_rdata = data; m_rresp = resp;
      tick();
      n = 0;
      while (s_rvalid === 4'b0 && n < 40) begin tick(); n++; end
      m_rvalid = 1'b0;
      if (s_rvalid === 4'b0) begin to = 1'b1; return; end
      rv = s_rvalid;
      rd = s_rdata[g*DW +: DW];
      rr = s_rresp[g*2 +: 2];
      n = 0;
      while (s_rvalid !== 4'b0 && n < 40) begin tick(); n++; end
      if (s_rvalid !== 4'b0) to = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      s_araddr = '0; s_arprot = '0; s_arvalid = '0; s_rready = '0;
      m_arready = 1'b0; m_rdata = '0; m_rresp = '0; m_rvalid = 1'b0;
      tick(); tick();
      checks++; if (s_arready !== 4'b0) $display("FAIL reset_arready: got %b expected 0000", s_arready); else passes++;
      checks++; if (s_rvalid !== 4'b0) $display("FAIL reset_rvalid: got %b expected 0000", s_rvalid); else passes++;
      checks++; if (m_arvalid !== 1'b0) $display("FAIL reset_m_arvalid: got %b expected 0", m_arvalid); else passes++;
      checks++; if (m_rready !== 1'b0) $display("FAIL reset_m_rready: got %b expected 0", m_rready); else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passes++;
      checks++; if (grant !== 2'd0) $display("FAIL reset_grant: got %0d expected 0", grant); else passes++;
      rst_n = 1'b1;
      m_rvalid = 1'b1;
      tick();
      m_rvalid = 1'b0;
      checks++; if ({busy, m_rready, s_rvalid} !== 6'b0) $display("FAIL idle_stray_rvalid: got %b expected 000000", {busy, m_rready, s_rvalid}); else passes++;
   endtask

   task automatic test_single();
      s_rready = '0;
      set_req(2, 32'h0000_1000, 3'b010, 1'b1);
      tick();
      checks++; if (s_arready !== 4'b0100) $display("FAIL single_arready: got %b expected 0100", s_arready); else passes++;
      checks++; if (grant !== 2'd2) $display("FAIL single_grant: got %0d expected 2", grant); else passes++;
      checks++; if (busy !== 1'b1) $display("FAIL single_busy: got %b expected 1", busy); else passes++;
      checks++; if (m_arvalid !== 1'b0) $display("FAIL single_early_arvalid: got %b expected 0", m_arvalid); else passes++;
      tick();
      checks++; if (m_arvalid !== 1'b1) $display("FAIL single_m_arvalid: got %b expected 1", m_arvalid); else passes++;
      checks++; if (m_araddr !== 32'h0000_1000) $display("FAIL single_m_araddr: got %h expected 00001000", m_araddr); else passes++;
      checks++; if (m_arprot !== 3'b010) $display("FAIL single_m_arprot: got %b expected 010", m_arprot); else passes++;
      checks++; if (s_arready !== 4'b0) $display("FAIL single_arready_drop: got %b expected 0000", s_arready); else passes++;
      s_arvalid[2] = 1'b0;
      m_arready = 1'b1;
      tick();
      m_arready = 1'b0;
      checks++; if ({m_arvalid, m_rready} !== 2'b01) $display("FAIL single_data_phase: got %b expected 01", {m_arvalid, m_rready}); else passes++;
      m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF; m_rresp = 2'b00;
      tick();
      m_rvalid = 1'b0;
      checks++; if (s_rvalid !== 4'b0100) $display("FAIL single_s_rvalid: got %b expected 0100", s_rvalid); else passes++;
      checks++; if (s_rdata[2*DW +: DW] !== 32'hDEAD_BEEF) $display("FAIL single_rdata: got %h expected deadbeef", s_rdata[2*DW +: DW]); else passes++;
      checks++; if (s_rresp[4 +: 2] !== 2'b00) $display("FAIL single_rresp: got %b expected 00", s_rresp[4 +: 2]); else passes++;
      checks++; if (m_rready !== 1'b0) $display("FAIL single_m_rready_drop: got %b expected 0", m_rready); else passes++;
      s_rready[2] = 1'b1;
      tick();
      checks++; if ({s_rvalid, busy} !== 5'b0) $display("FAIL single_done: got %b expected 00000", {s_rvalid, busy}); else passes++;
      checks++; if (grant !== 2'd2) $display("FAIL single_grant_hold: got %0d expected 2", grant); else passes++;
      s_rready = '1;
   endtask

   task automatic test_fairness();
      int g; logic [31:0] a; logic [3:0] rv; logic [31:0] rd; logic [1:0] rr; bit to;
      int exp_g; logic [3:0] exp_rv;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      s_rready = '1;
      for (int p = 0; p < S; p++) set_req(p, 32'h100 * (p + 1), 3'(p), 1'b1);
      for (int k = 0; k < 6; k++) begin
         serve(32'hA000_0000 + k, 2'b00, 1'b1, g, a, rv, rd, rr, to);
         exp_g  = k % 4;
         exp_rv = 4'b0001 << exp_g;
         checks++; if (to !== 1'b0) $display("FAIL fair_timeout: round %0d got %b expected 0", k, to); else passes++;
         checks++; if (g !== exp_g) $display("FAIL fair_grant: round %0d got %0d expected %0d", k, g, exp_g); else passes++;
         checks++; if (a !== 32'h100 * (exp_g + 1)) $display("FAIL fair_addr: round %0d got %h expected %h", k, a, 32'h100 * (exp_g + 1)); else passes++;
         checks++; if (rv !== exp_rv) $display("FAIL fair_rvalid: round %0d got %b expected %b", k, rv, exp_rv); else passes++;
         checks++; if (rd !== 32'hA000_0000 + k) $display("FAIL fair_rdata: round %0d got %h expected %h", k, rd, 32'hA000_0000 + k); else passes++;
      end
      s_arvalid = '0;
   endtask

   task automatic test_back_pressure();
      int g; logic [31:0] a; logic [3:0] rv; logic [31:0] rd; logic [1:0] rr; bit to;
      int n;
      s_rready = 4'b1101;
      set_req(1, 32'h2222_0000, 3'b001, 1'b1);
      n = 0;
      while (s_arready[1] !== 1'b1 && n < 20) begin tick(); n++; end
      checks++; if (s_arready !== 4'b0010) $display("FAIL bp_arready: got %b expected 0010", s_arready); else passes++;
      checks++; if (grant !== 2'd1) $display("FAIL bp_grant: got %0d expected 1", grant); else passes++;
      tick();
      s_arvalid[1] = 1'b0;
      set_req(0, 32'h0000_0A00, 3'b000, 1'b1);
      set_req(3, 32'h0000_3A00, 3'b000, 1'b1);
      for (int c = 0; c < 10; c++) begin
         checks++;
         if ({m_arvalid, m_araddr, grant, s_arready} !== {1'b1, 32'h2222_0000, 2'd1, 4'b0000})
            $display("FAIL bp_addr_hold: cycle %0d got %h expected %h", c,
                     {m_arvalid, m_araddr, grant, s_arready}, {1'b1, 32'h2222_0000, 2'd1, 4'b0000});
         else passes++;
         tick();
      end
      m_arready = 1'b1;
      tick();
      m_arready = 1'b0;
      m_rvalid = 1'b1; m_rdata = 32'h5555_AAAA; m_rresp = 2'b00;
      tick();
      m_rvalid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         checks++;
         if ({s_rvalid, s_rdata[DW +: DW], grant, s_arready} !== {4'b0010, 32'h5555_AAAA, 2'd1, 4'b0000})
            $display("FAIL bp_data_hold: cycle %0d got %h expected %h", c,
                     {s_rvalid, s_rdata[DW +: DW], grant, s_arready}, {4'b0010, 32'h5555_AAAA, 2'd1, 4'b0000});
         else passes++;
         tick();
      end
      s_rready = '1;
      tick();
      checks++; if ({busy, s_rvalid} !== 5'b0) $display("FAIL bp_release: got %b expected 00000", {busy, s_rvalid}); else passes++;
      serve(32'h3333_0003, 2'b00, 1'b0, g, a, rv, rd, rr, to);
      checks++; if ({to, g[1:0], a} !== {1'b0, 2'd3, 32'h0000_3A00}) $display("FAIL bp_next_port3: got %h expected %h", {to, g[1:0], a}, {1'b0, 2'd3, 32'h0000_3A00}); else passes++;
      serve(32'h0000_0000, 2'b00, 1'b0, g, a, rv, rd, rr, to);
      checks++; if ({to, g[1:0], a} !== {1'b0, 2'd0, 32'h0000_0A00}) $display("FAIL bp_next_port0: got %h expected %h", {to, g[1:0], a}, {1'b0, 2'd0, 32'h0000_0A00}); else passes++;
   endtask

   task automatic test_error_resp();
      int g; logic [31:0] a; logic [3:0] rv; logic [31:0] rd; logic [1:0] rr; bit to;
      set_req(2, 32'h0000_3000, 3'b000, 1'b1);
      serve(32'h0BAD_F00D, 2'b10, 1'b0, g, a, rv, rd, rr, to);
      checks++; if ({to, g[1:0]} !== {1'b0, 2'd2}) $display("FAIL err_grant: got %b expected 010", {to, g[1:0]}); else passes++;
      checks++; if (rr !== 2'b10) $display("FAIL err_rresp: got %b expected 10", rr); else passes++;
      checks++; if (rd !== 32'h0BAD_F00D) $display("FAIL err_rdata: got %h expected 0badf00d", rd); else passes++;
      set_req(1, 32'h0000_4000, 3'b000, 1'b1);
      serve(32'h1234_5678, 2'b00, 1'b0, g, a, rv, rd, rr, to);
      checks++; if ({to, g[1:0], a} !== {1'b0, 2'd1, 32'h0000_4000}) $display("FAIL err_next_req: got %h expected %h", {to, g[1:0], a}, {1'b0, 2'd1, 32'h0000_4000}); else passes++;
      checks++; if ({rr, rd} !== {2'b00, 32'h1234_5678}) $display("FAIL err_next_data: got %h expected %h", {rr, rd}, {2'b00, 32'h1234_5678}); else passes++;
   endtask

   task automatic test_reset_in_data();
      int g; logic [31:0] a; logic [3:0] rv; logic [31:0] rd; logic [1:0] rr; bit to;
      int n;
      set_req(0, 32'h0000_5000, 3'b000, 1'b1);
      n = 0;
      while (m_arvalid !== 1'b1 && n < 20) begin tick(); n++; end
      checks++; if (grant !== 2'd0) $display("FAIL rst_pre_grant: got %0d expected 0", grant); else passes++;
      s_arvalid[0] = 1'b0;
      m_arready = 1'b1;
      tick();
      m_arready = 1'b0;
      checks++; if ({m_rready, busy} !== 2'b11) $display("FAIL rst_in_data: got %b expected 11", {m_rready, busy}); else passes++;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++; if ({s_arready, s_rvalid, m_arvalid, m_rready, busy} !== 11'b0) $display("FAIL rst_abort: got %b expected 00000000000", {s_arready, s_rvalid, m_arvalid, m_rready, busy}); else passes++;
      checks++; if (grant !== 2'd0) $display("FAIL rst_abort_grant: got %0d expected 0", grant); else passes++;
      set_req(3, 32'h0000_6000, 3'b101, 1'b1);
      serve(32'hCAFE_F00D, 2'b00, 1'b0, g, a, rv, rd, rr, to);
      checks++; if ({to, g[1:0], a} !== {1'b0, 2'd3, 32'h0000_6000}) $display("FAIL rst_fresh_req: got %h expected %h", {to, g[1:0], a}, {1'b0, 2'd3, 32'h0000_6000}); else passes++;
      checks++; if ({rv, rd} !== {4'b1000, 32'hCAFE_F00D}) $display("FAIL rst_fresh_data: got %h expected %h", {rv, rd}, {4'b1000, 32'hCAFE_F00D}); else passes++;
   endtask

   task automatic test_back_to_back();
      int g; logic [31:0] a; logic [3:0] rv; logic [31:0] rd; logic [1:0] rr; bit to;
      int n;
      s_rready = '0;
      set_req(3, 32'h0000_7000, 3'b000, 1'b1);
      n = 0;
      while (m_arvalid !== 1'b1 && n < 20) begin tick(); n++; end
      s_arvalid[3] = 1'b0;
      m_arready = 1'b1;
      tick();
      m_arready = 1'b0;
      m_rvalid = 1'b1; m_rdata = 32'h0000_0077; m_rresp = 2'b00;
      tick();
      m_rvalid = 1'b0;
      checks++; if (s_rvalid !== 4'b1000) $display("FAIL b2b_resp: got %b expected 1000", s_rvalid); else passes++;
      s_rready[3] = 1'b1;
      set_req(0, 32'h0000_8000, 3'b000, 1'b1);
      tick();
      checks++; if ({busy, s_rvalid, s_arready} !== 9'b0) $display("FAIL b2b_idle_gap: got %b expected 000000000", {busy, s_rvalid, s_arready}); else passes++;
      tick();
      checks++; if ({grant, s_arready} !== {2'd0, 4'b0001}) $display("FAIL b2b_grant0: got %b expected 000001", {grant, s_arready}); else passes++;
      s_rready = '1;
      serve(32'h0000_0088, 2'b00, 1'b0, g, a, rv, rd, rr, to);
      checks++; if ({to, g[1:0], a, rd} !== {1'b0, 2'd0, 32'h0000_8000, 32'h0000_0088}) $display("FAIL b2b_port0_txn: got %h expected %h", {to, g[1:0], a, rd}, {1'b0, 2'd0, 32'h0000_8000, 32'h0000_0088}); else passes++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_back_pressure();
      test_error_resp();
      test_reset_in_data();
      test_back_to_back();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
